// File: rtl/fetch_queue.sv
// fetch_queue: dual-wide in-order instruction queue between fetch and the two decode slots.
// Optional combinational empty-queue forwarding is enabled by defining FETCH_QUEUE_BYPASS_EN.

module fetch_queue_slot #(
  parameter int XLEN = 32
) (
  input  logic              vld,
  input  logic              byp,
  input  logic [2*XLEN-1:0] q_ent,
  input  logic [2*XLEN-1:0] in_ent,
  output logic [XLEN-1:0]   instr,
  output logic [XLEN-1:0]   pc
);
  logic [2*XLEN-1:0] ent;

  always_comb begin
    ent   = byp ? in_ent : q_ent;
    instr = '0;
    pc    = '0;
    // an empty slot presents an all-zero instruction, which decode treats as a bubble
    if (vld) begin
      instr = ent[2*XLEN-1:XLEN];
      pc    = ent[XLEN-1:0];
    end
  end
endmodule

module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [1:0]      in_valid,
  input  logic [XLEN-1:0] in_instr0,
  input  logic [XLEN-1:0] in_instr1,
  input  logic [XLEN-1:0] in_pc0,
  input  logic [XLEN-1:0] in_pc1,
  output logic            in_ready,
  output logic [1:0]      out_valid,
  output logic [XLEN-1:0] out_instr0,
  output logic [XLEN-1:0] out_instr1,
  output logic [XLEN-1:0] out_pc0,
  output logic [XLEN-1:0] out_pc1,
  input  logic [1:0]      deq_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fq_ent_t;

  fq_ent_t              mem_q [DEPTH];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        count;
  logic [1:0]           enq_n, deq_n, avail;
  logic [1:0]           q_vld;
  logic                 byp;
  logic [AW-1:0]        ra0, ra1, wa0, wa1;
  logic [1:0][2*XLEN-1:0] q_ent, in_ent;
  logic [1:0][XLEN-1:0] slot_instr, slot_pc;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign in_ready = (count <= PW'(DEPTH - 2));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = (count == '0) && !flush;
`else
  assign byp = 1'b0;
`endif

  assign ra0 = rd_ptr_q[AW-1:0];
  assign ra1 = rd_ptr_q[AW-1:0] + AW'(1);
  assign wa0 = wr_ptr_q[AW-1:0];
  assign wa1 = wr_ptr_q[AW-1:0] + AW'(1);

  assign q_vld[0] = (count >= PW'(1));
  assign q_vld[1] = (count >= PW'(2));

  assign q_ent[0]  = mem_q[ra0];
  assign q_ent[1]  = mem_q[ra1];
  assign in_ent[0] = {in_instr0, in_pc0};
  assign in_ent[1] = {in_instr1, in_pc1};

  always_comb begin
    out_valid = q_vld;
    // 2'b10 from fetch is illegal; squash it so decode never sees a hole in slot 0
    if (byp) out_valid = {in_valid[1] & in_valid[0], in_valid[0]};
    avail = out_valid[1] ? 2'd2 : (out_valid[0] ? 2'd1 : 2'd0);
    deq_n = (deq_cnt > avail) ? avail : deq_cnt;
    enq_n = 2'd0;
    if (in_ready && !flush && in_valid[0]) enq_n = in_valid[1] ? 2'd2 : 2'd1;
  end

  genvar s;
  generate
    for (s = 0; s < 2; s++) begin : g_slot
      fetch_queue_slot #(.XLEN(XLEN)) u_slot (
        .vld    (out_valid[s]),
        .byp    (byp),
        .q_ent  (q_ent[s]),
        .in_ent (in_ent[s]),
        .instr  (slot_instr[s]),
        .pc     (slot_pc[s])
      );
    end
  endgenerate

  assign out_instr0 = slot_instr[0];
  assign out_instr1 = slot_instr[1];
  assign out_pc0    = slot_pc[0];
  assign out_pc1    = slot_pc[1];

  // Forwarded entries are written and then skipped by rd_ptr in the same edge,
  // so the bypass case needs no separate write path.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(deq_n);
    wr_ptr_d = wr_ptr_q + PW'(enq_n);
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_n != 2'd0) mem_q[wa0] <= in_ent[0];
    if (enq_n == 2'd2) mem_q[wa1] <= in_ent[1];
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (deq_cnt <= avail)
        else $error("fetch_queue: deq_cnt %0d exceeds available %0d", deq_cnt, avail);
      assert (in_valid != 2'b10)
        else $error("fetch_queue: in_valid=10 from fetch");
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [1:0]      in_valid = 2'b00;
  logic [XLEN-1:0] in_instr0 = '0, in_instr1 = '0, in_pc0 = '0, in_pc1 = '0;
  logic [1:0]      deq_cnt = 2'd0;
  logic            in_ready;
  logic [1:0]      out_valid;
  logic [XLEN-1:0] out_instr0, out_instr1, out_pc0, out_pc1;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_instr0(in_instr0), .in_instr1(in_instr1), .in_pc0(in_pc0), .in_pc1(in_pc1),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_instr0(out_instr0), .out_instr1(out_instr1), .out_pc0(out_pc0), .out_pc1(out_pc1),
    .deq_cnt(deq_cnt)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  logic [63:0] mq[$];
  logic [31:0] pc_next = 32'h100;
  logic [31:0] salt = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errs++;
        $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    if (pc == 32'h100) return 32'h0000_0013;
    if (pc == 32'h104) return 32'h0010_0093;
    return {pc[15:0] ^ 16'h5a5a, pc[15:0]} ^ salt;
  endfunction

  // One cycle: drive inputs at negedge, check outputs, then advance the model at posedge.
  task automatic step(input logic [1:0] iv, input logic [1:0] dq_req, input logic fl);
    int sz = mq.size();
    logic rdy = ((DEPTH - sz) >= 2);
    logic byp = 1'b0;
    logic [1:0] ev;
    logic [63:0] e0, e1;
    int av, dq;
    in_valid  = iv;
    flush     = fl;
    in_pc0    = pc_next;
    in_pc1    = pc_next + 32'd4;
    in_instr0 = instr_of(pc_next);
    in_instr1 = instr_of(pc_next + 32'd4);
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sz == 0) && !fl;
`endif
    if (byp) begin
      ev = iv;
      e0 = iv[0] ? {in_instr0, in_pc0} : 64'h0;
      e1 = iv[1] ? {in_instr1, in_pc1} : 64'h0;
    end else begin
      ev = (sz >= 2) ? 2'b11 : (sz >= 1) ? 2'b01 : 2'b00;
      e0 = (sz >= 1) ? mq[0] : 64'h0;
      e1 = (sz >= 2) ? mq[1] : 64'h0;
    end
    av = ev[1] ? 2 : (ev[0] ? 1 : 0);
    dq = (int'(dq_req) > av) ? av : int'(dq_req);
    deq_cnt = 2'(dq);
    #1;
    chk("out_valid",  {30'h0, out_valid}, {30'h0, ev});
    chk("out_instr0", out_instr0, e0[63:32]);
    chk("out_pc0",    out_pc0,    e0[31:0]);
    chk("out_instr1", out_instr1, e1[63:32]);
    chk("out_pc1",    out_pc1,    e1[31:0]);
    chk("in_ready",   {31'h0, in_ready}, {31'h0, rdy});
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (rdy && iv[0]) begin
        mq.push_back({instr_of(pc_next), pc_next});
        pc_next += 32'd4;
        if (iv[1]) begin
          mq.push_back({instr_of(pc_next), pc_next});
          pc_next += 32'd4;
        end
      end
      for (int k = 0; k < dq; k++) void'(mq.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    mq.delete();
    chk("rst_out_valid",  {30'h0, out_valid}, 32'h0);
    chk("rst_out_instr0", out_instr0, 32'h0);
    chk("rst_out_instr1", out_instr1, 32'h0);
    chk("rst_in_ready",   {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] riv;
    // reset state
    do_reset();

    // fill: ready drops once 4 pairs are held, the 5th pair is dropped
    for (int i = 0; i < 4; i++) step(2'b11, 2'd0, 1'b0);
    #1;
    chk("fill_in_ready_low", {31'h0, in_ready}, 32'h0);
    chk("fill_model_count", mq.size(), 32'd8);
    step(2'b11, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(2'b00, 2'd2, 1'b0);

    // order across several pointer wraps
    pc_next = 32'h100;
    for (int i = 0; i < 30; i++) step(2'b11, 2'd2, 1'b0);
    for (int i = 0; i < 2; i++) step(2'b00, 2'd2, 1'b0);

    // odd counts
    for (int i = 0; i < 3; i++) step(2'b01, 2'd1, 1'b0);
    for (int i = 0; i < 2; i++) step(2'b00, 2'd1, 1'b0);

    // reset mid-stream
    step(2'b11, 2'd0, 1'b0);
    step(2'b11, 2'd1, 1'b0);
    do_reset();
    step(2'b00, 2'd0, 1'b0);

    // flush with 5 entries held, while a new pair and a dequeue are offered
    step(2'b11, 2'd0, 1'b0);
    step(2'b11, 2'd0, 1'b0);
    step(2'b01, 2'd0, 1'b0);
    chk("flush_pre_count", mq.size(), 32'd5);
    step(2'b11, 2'd2, 1'b1);
    #1;
    chk("flush_out_valid", {30'h0, out_valid}, 32'h0);
    step(2'b00, 2'd0, 1'b0);

`ifdef FETCH_QUEUE_BYPASS_EN
    step(2'b11, 2'd1, 1'b0);
    chk("bypass_count", mq.size(), 32'd1);
    step(2'b00, 2'd1, 1'b0);
`endif

    // random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      salt = $urandom;
      case ($urandom_range(0, 2))
        0: riv = 2'b00;
        1: riv = 2'b01;
        default: riv = 2'b11;
      endcase
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(riv, 2'($urandom_range(0, 2)), ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
